hazard_sequencer: RTL

HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

---
 rtl/mips_pkg.sv | 18 +
 rtl/hazard_detect.sv | 38 +++
 rtl/hazard_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the hazard sequencer state encoding.
// Imported by hazard_detect and hazard_sequencer.
package mips_pkg;

    localparam logic [5:0] RTYPE = 6'h00;
    localparam logic [5:0] LW    = 6'h23;
    localparam logic [5:0] SW    = 6'h2B;
    localparam logic [5:0] BEQ   = 6'h04;
    localparam logic [5:0] JUMP  = 6'h02;

    localparam int LU_CNT_W = 3;

    typedef enum logic [1:0] {
        SEQ_RUN      = 2'd0,
        SEQ_LU_STALL = 2'd1
    } seq_state_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hit detection: decodes which source registers the
// ID instruction reads and matches them against the EX load destination.
module hazard_detect
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [4:0] i_rs,
    input  logic [4:0] i_rt,
    input  logic       i_mem_read_ex,
    input  logic [4:0] i_rt_ex,
    output logic       o_hit
);

    logic w_use_rs;
    logic w_use_rt;
    logic w_rs_match;
    logic w_rt_match;

    always_comb begin
        w_use_rs = 1'b0;
        w_use_rt = 1'b0;
        case (i_opcode)
            RTYPE, SW, BEQ: begin
                w_use_rs = 1'b1;
                w_use_rt = 1'b1;
            end
            LW:      w_use_rs = 1'b1;
            JUMP:    ;
            default: ;
        endcase
    end

    // $zero is never a real dependency, so a load to r0 cannot stall.
    assign w_rs_match = w_use_rs && (i_rs == i_rt_ex);
    assign w_rt_match = w_use_rt && (i_rt == i_rt_ex);
    assign o_hit      = i_mem_read_ex && (i_rt_ex != 5'd0) && (w_rs_match || w_rt_match);

endmodule

// File: rtl/hazard_sequencer.sv
// Load-use stall / branch-jump flush sequencer with optional perf counters.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush counters.
module hazard_sequencer
    import mips_pkg::*;
#(
    parameter int LU_STALL_CYC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instruction_ID,
    input  logic        MemRead_EX,
    input  logic [4:0]  RegisterRt_EX,
    input  logic        Branch_taken_MEM,
    input  logic        Jump_control_ID,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic        ID_Control_Noop,
    output logic        IFID_Flush,
    output logic        IDEX_Flush,
    output logic        EXMEM_Flush,
    output logic [1:0]  seq_state,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [LU_CNT_W-1:0] CNT_LOAD = LU_CNT_W'(LU_STALL_CYC - 1);

    seq_state_e          r_state;
    logic [LU_CNT_W-1:0] r_cnt;
    logic                w_hit;
    logic                w_run;
    logic                w_bubble;
    logic                w_jump;
    logic                w_unused_imm;

    hazard_detect u_detect (
        .i_opcode      (Instruction_ID[31:26]),
        .i_rs          (Instruction_ID[25:21]),
        .i_rt          (Instruction_ID[20:16]),
        .i_mem_read_ex (MemRead_EX),
        .i_rt_ex       (RegisterRt_EX),
        .o_hit         (w_hit)
    );

    assign w_unused_imm = ^Instruction_ID[15:0];

    // Bubble and jump are only meaningful when no branch is flushing the pipe.
    assign w_run    = (r_state == SEQ_RUN);
    assign w_bubble = !Branch_taken_MEM && ((r_state == SEQ_LU_STALL) || (w_run && w_hit));
    assign w_jump   = !Branch_taken_MEM && w_run && !w_hit && Jump_control_ID;

    always_comb begin
        PC_Write        = 1'b1;
        IFID_Write      = 1'b1;
        ID_Control_Noop = 1'b0;
        IFID_Flush      = 1'b0;
        IDEX_Flush      = 1'b0;
        EXMEM_Flush     = 1'b0;
        if (!rst_n) begin
            PC_Write        = 1'b0;
            IFID_Write      = 1'b0;
            ID_Control_Noop = 1'b1;
            IFID_Flush      = 1'b1;
            IDEX_Flush      = 1'b1;
            EXMEM_Flush     = 1'b1;
        end else if (Branch_taken_MEM) begin
            IFID_Flush  = 1'b1;
            IDEX_Flush  = 1'b1;
            EXMEM_Flush = 1'b1;
        end else if (w_bubble) begin
            PC_Write        = 1'b0;
            IFID_Write      = 1'b0;
            ID_Control_Noop = 1'b1;
        end else if (w_jump) begin
            IFID_Flush = 1'b1;
        end
    end

    // r_cnt holds the bubbles still owed after the current one.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SEQ_RUN;
            r_cnt   <= '0;
        end else if (Branch_taken_MEM) begin
            r_state <= SEQ_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                SEQ_RUN: begin
                    if (w_hit && (LU_STALL_CYC > 1)) begin
                        r_state <= SEQ_LU_STALL;
                        r_cnt   <= CNT_LOAD;
                    end
                end
                SEQ_LU_STALL: begin
                    if (r_cnt <= LU_CNT_W'(1)) begin
                        r_state <= SEQ_RUN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt - LU_CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= SEQ_RUN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign seq_state = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        w_flush_ev;

    assign w_flush_ev = Branch_taken_MEM || w_jump;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_bubble && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (w_flush_ev && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule
